scan_sequencer: RTL and testbench

- Upstream code generator for the 3-to-8 binary decoder.
- Steps a registered 3-bit select through the enabled positions of an 8-bit mask, holding each position for a programmable number of cycles and wrapping circularly.
- Its `sel` output drives the decoder's 3-bit `in`; the decoder's one-hot output then strobes one of eight loads, e.g. multiplexed display digits or scanned channels.
- All outputs are registered.

---
 rtl/scan_sequencer.sv | 126 ++++++++++++
 tb/tb_scan_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks a registered 3-bit select through the set bits of an 8-bit mask,
// dwelling dwell+1 cycles per position. Optional `SCAN_SEQ_HOLD_EN adds a hold input.
//
//   state | meaning
//   IDLE  | not scanning, sel_valid low, sel holds last position
//   DWELL | sel active, counting cycles until advance to next set mask bit
module scan_sequencer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SEQ_HOLD_EN
    input  logic               hold,
`endif
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               tick,
    output logic               wrap
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t             state, state_nx;
    logic [2:0]         sel_nx;
    logic               valid_nx, tick_nx, wrap_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [2:0]         adv_sel;
    logic               stop;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Circular search starting one past cur; the last probe (offset 8) lands on cur itself,
    // so a mask with only the current bit set re-selects it.
    function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign adv_sel = next_bit(mask, sel);
    assign stop    = !en || (mask == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            sel_valid <= valid_nx;
            tick      <= tick_nx;
            wrap      <= wrap_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        valid_nx = sel_valid;
        tick_nx  = 1'b0;
        wrap_nx  = 1'b0;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                cnt_nx   = '0;
                if (!stop) begin
                    state_nx = DWELL;
                    sel_nx   = lowest_bit(mask);
                    valid_nx = 1'b1;
                    tick_nx  = 1'b1;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                    cnt_nx   = '0;
`ifdef SCAN_SEQ_HOLD_EN
                end else if (hold) begin
                    cnt_nx = cnt;
`endif
                end else if (cnt >= dwell) begin
                    // >= so a dwell lowered below cnt advances immediately
                    sel_nx  = adv_sel;
                    tick_nx = 1'b1;
                    wrap_nx = (adv_sel <= sel);
                    cnt_nx  = '0;
                end else begin
                    cnt_nx = cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: a directed vector table plus hand-written
// multi-cycle sequences (full scan, stop/restart, live dwell/mask changes, optional hold).
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [7:0]  mask;
    logic [15:0] dwell;
`ifdef SCAN_SEQ_HOLD_EN
    logic        hold = 1'b0;
`endif
    logic [2:0]  sel;
    logic        sel_valid, tick, wrap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mask      (mask),
        .dwell     (dwell),
`ifdef SCAN_SEQ_HOLD_EN
        .hold      (hold),
`endif
        .sel       (sel),
        .sel_valid (sel_valid),
        .tick      (tick),
        .wrap      (wrap)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [7:0]  mask;
        logic [15:0] dwell;
        logic [2:0]  sel;
        logic        valid;
        logic        tick;
        logic        wrap;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] m,
                                input logic [15:0] d, input logic [2:0] s,
                                input logic v, input logic t, input logic w);
        vec_t x;
        x.rst_n = r; x.en = e; x.mask = m; x.dwell = d;
        x.sel = s; x.valid = v; x.tick = t; x.wrap = w;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] s, input logic v,
                           input logic t, input logic w);
        chk({name, ".sel"},   32'(sel),       32'(s));
        chk({name, ".valid"}, 32'(sel_valid), 32'(v));
        chk({name, ".tick"},  32'(tick),      32'(t));
        chk({name, ".wrap"},  32'(wrap),      32'(w));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_sel;
        logic exp_tick;
        reset_n = 1'b0; en = 1'b0; mask = 8'h00; dwell = 16'd0;

        //            rst en mask   dwell sel v  t  w
        vecs[0]  = mk(0, 1, 8'hFF, 16'd0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'hFF, 16'd0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 8'hFF, 16'd0, 0, 1, 1, 0);
        vecs[3]  = mk(1, 0, 8'hFF, 16'd0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 8'hA4, 16'd0, 2, 1, 1, 0);
        vecs[5]  = mk(1, 1, 8'hA4, 16'd0, 5, 1, 1, 0);
        vecs[6]  = mk(1, 1, 8'hA4, 16'd0, 7, 1, 1, 0);
        vecs[7]  = mk(1, 1, 8'hA4, 16'd0, 2, 1, 1, 1);
        vecs[8]  = mk(1, 1, 8'hA4, 16'd0, 5, 1, 1, 0);
        vecs[9]  = mk(1, 1, 8'h10, 16'd0, 4, 1, 1, 1);
        vecs[10] = mk(1, 1, 8'h10, 16'd0, 4, 1, 1, 1);
        vecs[11] = mk(1, 1, 8'h10, 16'd0, 4, 1, 1, 1);
        vecs[12] = mk(1, 1, 8'h00, 16'd0, 4, 0, 0, 0);
        vecs[13] = mk(1, 1, 8'h10, 16'd0, 4, 1, 1, 0);
        vecs[14] = mk(1, 0, 8'h10, 16'd0, 4, 0, 0, 0);

        step();
        for (int i = 0; i < 15; i++) begin
            reset_n = vecs[i].rst_n;
            en      = vecs[i].en;
            mask    = vecs[i].mask;
            dwell   = vecs[i].dwell;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].tick, vecs[i].wrap);
        end

        // Full scan, dwell=2: each position held 3 cycles, wrap only on 7->0
        do_reset();
        en = 1'b1; mask = 8'hFF; dwell = 16'd2;
        for (int c = 0; c < 8 * 3 + 2; c++) begin
            step();
            exp_sel  = (c / 3) % 8;
            exp_tick = (c % 3 == 0);
            chk_out($sformatf("scan_c%0d", c), 3'(exp_sel), 1'b1, exp_tick,
                    exp_tick && (c >= 3) && (exp_sel == 0));
        end

        // Stop at sel=3 cnt=3 with dwell=5, then restart from lowest bit of a new mask
        do_reset();
        en = 1'b1; mask = 8'hFF; dwell = 16'd5;
        for (int c = 0; c < 22; c++) step();
        chk_out("stop_pre", 3'd3, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk_out("stop", 3'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("stop_idle", 3'd3, 1'b0, 1'b0, 1'b0);
        mask = 8'h24; en = 1'b1;
        step();
        chk_out("restart", 3'd2, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out($sformatf("restart_dw%0d", c), 3'd2, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_out("restart_adv", 3'd5, 1'b1, 1'b1, 1'b0);

        // Live dwell reduction below cnt advances on the next edge; mask=0 stops
        do_reset();
        en = 1'b1; mask = 8'hFF; dwell = 16'd10;
        for (int c = 0; c < 20; c++) step();
        chk_out("live_pre", 3'd1, 1'b1, 1'b0, 1'b0);
        dwell = 16'd4;
        step();
        chk_out("live_dwell", 3'd2, 1'b1, 1'b1, 1'b0);
        mask = 8'h00;
        step();
        chk_out("live_mask0", 3'd2, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_SEQ_HOLD_EN
        // Hold 4 cycles mid-dwell with dwell=3: position lasts 8 cycles
        do_reset();
        en = 1'b1; mask = 8'hFF; dwell = 16'd3;
        step();
        chk_out("hold_entry", 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("hold_h%0d", c), 3'd0, 1'b1, 1'b0, 1'b0);
        end
        hold = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk_out($sformatf("hold_r%0d", c), 3'd0, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_out("hold_adv", 3'd1, 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
